// File: rtl/icon_tx_requester.sv
// Interconnect TX-port initiator: queues operand-fetch requests, polls the producing EU
// until success or timeout, and returns data/tag/error on a valid/ready response channel.
module icon_tx_requester #(
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 32,
    parameter int TAG_W      = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int MAX_POLL   = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [TAG_W-1:0]  req_tag_i,
    output logic [ADDR_W-1:0] eu_tx_addr_o,
    output logic              eu_tx_req_valid_o,
    input  logic [DATA_W-1:0] eu_tx_data_i,
    input  logic              eu_tx_success_i,
    output logic              resp_valid_o,
    input  logic              resp_ready_i,
    output logic [DATA_W-1:0] resp_data_o,
    output logic [TAG_W-1:0]  resp_tag_o,
    output logic              resp_err_o,
    output logic              busy_o,
    output logic [7:0]        timeout_cnt_o
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(MAX_POLL + 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] RESP  = 2'd2;

    logic [1:0]        state;
    logic [ADDR_W-1:0] addr_mem [FIFO_DEPTH];
    logic [TAG_W-1:0]  tag_mem  [FIFO_DEPTH];
    logic [PW:0]       wr_ptr;
    logic [PW:0]       rd_ptr;
    logic              full;
    logic              empty;
    logic              push;
    logic              pop;
    logic              last_poll;
    logic [CW-1:0]     poll_cnt;
    logic [ADDR_W-1:0] cur_addr;
    logic [TAG_W-1:0]  cur_tag;
    logic [DATA_W-1:0] data;
    logic              err;
    logic [7:0]        timeout_cnt;

    // Pointer MSB differs only when the write side has lapped the read side.
    assign empty     = (wr_ptr == rd_ptr);
    assign full      = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
    assign push      = req_valid_i && !full;
    assign pop       = (state == IDLE) && !empty;
    assign last_poll = (poll_cnt == CW'(MAX_POLL - 1));

    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem[wr_ptr[PW-1:0]] <= req_addr_i;
            tag_mem[wr_ptr[PW-1:0]]  <= req_tag_i;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            poll_cnt    <= '0;
            cur_addr    <= '0;
            cur_tag     <= '0;
            data        <= '0;
            err         <= 1'b0;
            timeout_cnt <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + (PW+1)'(1);
            if (pop)  rd_ptr <= rd_ptr + (PW+1)'(1);
            case (state)
                IDLE: begin
                    if (!empty) begin
                        cur_addr <= addr_mem[rd_ptr[PW-1:0]];
                        cur_tag  <= tag_mem[rd_ptr[PW-1:0]];
                        poll_cnt <= '0;
                        state    <= ISSUE;
                    end
                end
                ISSUE: begin
                    // Success is checked first so a hit on the final poll still wins.
                    if (eu_tx_success_i) begin
                        data  <= eu_tx_data_i;
                        err   <= 1'b0;
                        state <= RESP;
                    end else if (last_poll) begin
                        data  <= '0;
                        err   <= 1'b1;
                        state <= RESP;
                        if (timeout_cnt != 8'hFF) timeout_cnt <= timeout_cnt + 8'd1;
                    end else begin
                        poll_cnt <= poll_cnt + CW'(1);
                    end
                end
                RESP: begin
                    if (resp_ready_i) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign req_ready_o       = !full;
    assign eu_tx_addr_o      = cur_addr;
    assign eu_tx_req_valid_o = (state == ISSUE);
    assign resp_valid_o      = (state == RESP);
    assign resp_data_o       = data;
    assign resp_tag_o        = cur_tag;
    assign resp_err_o        = err;
    assign busy_o            = (state != IDLE) || !empty;
    assign timeout_cnt_o     = timeout_cnt;
endmodule

// File: tb/tb_icon_tx_requester.sv
// Bench for icon_tx_requester: timestamp-based request model checked every cycle,
// directed scenarios with literal expectations, then a randomized soak.
module tb_icon_tx_requester;
    localparam int DEPTH = 4;
    localparam int MPOLL = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid_i;
    logic        req_ready_o;
    logic [7:0]  req_addr_i;
    logic [3:0]  req_tag_i;
    logic [7:0]  eu_tx_addr_o;
    logic        eu_tx_req_valid_o;
    logic [31:0] eu_tx_data_i;
    logic        eu_tx_success_i;
    logic        resp_valid_o;
    logic        resp_ready_i;
    logic [31:0] resp_data_o;
    logic [3:0]  resp_tag_o;
    logic        resp_err_o;
    logic        busy_o;
    logic [7:0]  timeout_cnt_o;

    icon_tx_requester #(.ADDR_W(8), .DATA_W(32), .TAG_W(4), .FIFO_DEPTH(DEPTH), .MAX_POLL(MPOLL)) dut (
        .clk(clk), .reset(reset),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_addr_i(req_addr_i), .req_tag_i(req_tag_i),
        .eu_tx_addr_o(eu_tx_addr_o), .eu_tx_req_valid_o(eu_tx_req_valid_o),
        .eu_tx_data_i(eu_tx_data_i), .eu_tx_success_i(eu_tx_success_i),
        .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i),
        .resp_data_o(resp_data_o), .resp_tag_o(resp_tag_o), .resp_err_o(resp_err_o),
        .busy_o(busy_o), .timeout_cnt_o(timeout_cnt_o)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;

    // Stimulus knobs; succ_at < 0 means random success, otherwise success on that poll index.
    logic        drv_reset = 1'b0;
    logic        drv_rv = 1'b0;
    logic [7:0]  drv_addr = '0;
    logic [3:0]  drv_tag = '0;
    logic [31:0] drv_data = '0;
    logic        drv_ready = 1'b1;
    int          succ_at = -1;

    // Model: queued requests plus the cycle numbers at which the current request
    // started issuing and started responding (-1 while still polling).
    logic [7:0]  mq_addr[$];
    logic [3:0]  mq_tag[$];
    bit          cur = 0;
    int          cur_start = 0;
    int          cur_done = -1;
    logic [7:0]  m_addr = '0;
    logic [3:0]  m_tag = '0;
    logic [31:0] m_data = '0;
    logic        m_err = 1'b0;
    int          m_tcnt = 0;

    int          rv_cnt = 0;
    int          resp_seen = 0;
    logic [3:0]  hs_tags[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        bit e_issue, e_resp, s, acc;
        @(negedge clk);
        e_issue = cur && (cur_done < 0) && (cyc >= cur_start);
        e_resp  = cur && (cur_done >= 0);
        chk("req_ready", req_ready_o, 64'(mq_addr.size() < DEPTH));
        chk("busy", busy_o, 64'(cur || (mq_addr.size() > 0)));
        chk("eu_valid", eu_tx_req_valid_o, 64'(e_issue));
        chk("eu_addr", eu_tx_addr_o, m_addr);
        chk("resp_valid", resp_valid_o, 64'(e_resp));
        chk("timeout_cnt", timeout_cnt_o, 64'(m_tcnt));
        if (e_resp) begin
            chk("resp_data", resp_data_o, m_data);
            chk("resp_tag", resp_tag_o, m_tag);
            chk("resp_err", resp_err_o, m_err);
        end
        if (eu_tx_req_valid_o === 1'b1) rv_cnt++;
        if (resp_valid_o === 1'b1) resp_seen++;
        if (resp_valid_o === 1'b1 && drv_ready && !drv_reset) hs_tags.push_back(resp_tag_o);

        if (succ_at < 0) s = ($urandom_range(0, 3) == 0);
        else             s = e_issue && ((cyc - cur_start) == succ_at);

        reset           = drv_reset;
        req_valid_i     = drv_rv;
        req_addr_i      = drv_addr;
        req_tag_i       = drv_tag;
        eu_tx_success_i = s;
        eu_tx_data_i    = drv_data;
        resp_ready_i    = drv_ready;

        if (drv_reset) begin
            mq_addr.delete(); mq_tag.delete();
            cur = 0; cur_done = -1;
            m_addr = '0; m_tag = '0; m_data = '0; m_err = 1'b0; m_tcnt = 0;
        end else begin
            acc = drv_rv && (mq_addr.size() < DEPTH);
            if (!cur && mq_addr.size() > 0) begin
                cur = 1; cur_start = cyc + 1; cur_done = -1;
                m_addr = mq_addr.pop_front();
                m_tag  = mq_tag.pop_front();
            end else if (e_issue) begin
                if (s) begin
                    m_data = drv_data; m_err = 1'b0; cur_done = cyc + 1;
                end else if ((cyc - cur_start) == MPOLL - 1) begin
                    m_data = '0; m_err = 1'b1; cur_done = cyc + 1;
                    if (m_tcnt < 255) m_tcnt++;
                end
            end else if (e_resp && drv_ready) begin
                cur = 0;
            end
            if (acc) begin
                mq_addr.push_back(drv_addr);
                mq_tag.push_back(drv_tag);
            end
        end
        cyc++;
    endtask

    task automatic peek();
        @(posedge clk);
        #1;
    endtask

    task automatic push1(input logic [7:0] a, input logic [3:0] t);
        drv_rv = 1'b1; drv_addr = a; drv_tag = t;
        step();
        drv_rv = 1'b0;
    endtask

    task automatic wait_resp(input string name);
        bit got = 0;
        for (int i = 0; i < 100; i++) begin
            step();
            if (resp_valid_o === 1'b1) begin
                got = 1;
                break;
            end
        end
        if (!got) chk(name, 0, 1);
    endtask

    task automatic drain(input int n);
        drv_rv = 1'b0; drv_ready = 1'b1;
        repeat (n) step();
    endtask

    initial begin
        logic [31:0] held;
        reset = 1'b1; req_valid_i = 1'b0; req_addr_i = '0; req_tag_i = '0;
        eu_tx_data_i = '0; eu_tx_success_i = 1'b0; resp_ready_i = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", req_ready_o, 1);
        chk("rst_busy", busy_o, 0);
        chk("rst_resp_valid", resp_valid_o, 0);
        chk("rst_eu_valid", eu_tx_req_valid_o, 0);

        // T1: minimum latency, success on first poll
        succ_at = 0; drv_data = 32'hDEADBEEF; drv_ready = 1'b1;
        push1(8'h12, 4'd3);
        step(); step();
        peek();
        chk("t1_valid", resp_valid_o, 1);
        chk("t1_data", resp_data_o, 32'hDEADBEEF);
        chk("t1_tag", resp_tag_o, 3);
        chk("t1_err", resp_err_o, 0);
        drain(4);

        // T2: success on the fifth poll
        succ_at = 4; drv_data = 32'h0BADF00D; rv_cnt = 0;
        push1(8'h5A, 4'd7);
        wait_resp("t2_wait");
        chk("t2_polls", rv_cnt, 5);
        chk("t2_err", resp_err_o, 0);
        chk("t2_data", resp_data_o, 32'h0BADF00D);
        drain(4);

        // T3: timeout, then success on the very last poll
        succ_at = 999; drv_data = 32'h11111111; rv_cnt = 0;
        push1(8'h21, 4'd1);
        wait_resp("t3_wait");
        chk("t3_polls", rv_cnt, 16);
        chk("t3_err", resp_err_o, 1);
        chk("t3_data", resp_data_o, 0);
        chk("t3_tcnt", timeout_cnt_o, 1);
        drain(4);
        succ_at = 15; drv_data = 32'hCAFE0001; rv_cnt = 0;
        push1(8'h22, 4'd2);
        wait_resp("t3b_wait");
        chk("t3b_polls", rv_cnt, 16);
        chk("t3b_err", resp_err_o, 0);
        chk("t3b_data", resp_data_o, 32'hCAFE0001);
        chk("t3b_tcnt", timeout_cnt_o, 1);
        drain(4);

        // T4: fill the FIFO behind a stalled response, then check ordering
        succ_at = 0; drv_ready = 1'b0;
        for (int t = 0; t < 5; t++) push1(8'h40 + 8'(t), 4'(t));
        peek();
        chk("t4_full", req_ready_o, 0);
        hs_tags.delete();
        drain(40);
        chk("t4_count", hs_tags.size(), 5);
        for (int t = 0; t < 5 && t < hs_tags.size(); t++) chk("t4_order", hs_tags[t], t);

        // T5: ten cycles of backpressure in RESP
        succ_at = 0; drv_ready = 1'b0; drv_data = 32'h13572468;
        push1(8'h66, 4'd9);
        wait_resp("t5_wait");
        held = resp_data_o;
        push1(8'h67, 4'd10);
        drv_data = 32'hFFFF0000;
        repeat (9) step();
        chk("t5_valid", resp_valid_o, 1);
        chk("t5_data", resp_data_o, 32'h13572468);
        chk("t5_hold", resp_data_o, held);
        chk("t5_tag", resp_tag_o, 9);
        chk("t5_eu_valid", eu_tx_req_valid_o, 0);
        chk("t5_busy", busy_o, 1);
        drain(20);

        // T6: reset while issuing with two requests queued
        succ_at = 999; drv_ready = 1'b1;
        drv_rv = 1'b1;
        for (int t = 1; t <= 3; t++) begin
            drv_addr = 8'h70 + 8'(t); drv_tag = 4'(t);
            step();
        end
        drv_rv = 1'b0;
        drv_reset = 1'b1;
        step();
        chk("t6_in_issue", eu_tx_req_valid_o, 1);
        drv_reset = 1'b0;
        peek();
        chk("t6_ready", req_ready_o, 1);
        chk("t6_busy", busy_o, 0);
        chk("t6_eu_valid", eu_tx_req_valid_o, 0);
        chk("t6_eu_addr", eu_tx_addr_o, 0);
        chk("t6_resp_valid", resp_valid_o, 0);
        chk("t6_resp_data", resp_data_o, 0);
        chk("t6_resp_tag", resp_tag_o, 0);
        chk("t6_resp_err", resp_err_o, 0);
        chk("t6_tcnt", timeout_cnt_o, 0);
        resp_seen = 0;
        drain(30);
        chk("t6_no_resp", resp_seen, 0);

        // Randomized soak against the model
        succ_at = -1;
        for (int i = 0; i < 3000; i++) begin
            drv_reset = ($urandom_range(0, 399) == 0);
            drv_rv    = ($urandom_range(0, 1) == 1);
            drv_addr  = 8'($urandom);
            drv_tag   = 4'($urandom);
            drv_data  = $urandom;
            drv_ready = ($urandom_range(0, 4) < 3);
            step();
        end
        drv_reset = 1'b0;
        drain(40);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
